// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package risc23_pkg;
  localparam int REG_W     = 3;
  localparam int NREGS     = 8;
  localparam int ADDR_STEP = 2;

  typedef enum logic {HZ_IDLE = 1'b0, HZ_SEQ = 1'b1} hz_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// RF/EX observation inputs and stall/flush/micro-op controls of the hazard unit.
interface pipe_hazard_ctrl_if;
  import risc23_pkg::*;

  logic             rf_valid;
  logic [REG_W-1:0] rf_ra;
  logic [REG_W-1:0] rf_rb;
  logic             rf_use_ra;
  logic             rf_use_rb;
  logic             rf_is_lm;
  logic             rf_is_sm;
  logic [NREGS-1:0] rf_lmsm_mask;
  logic             ex_mem_rd;
  logic             ex_rf_we;
  logic [REG_W-1:0] ex_rf_waddr;
  logic             ex_redirect;

  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_rf_stall;
  logic             id_rf_flush;
  logic             rf_ex_flush;
  logic             uop_valid;
  logic [REG_W-1:0] uop_reg;
  logic [15:0]      uop_offset;
  logic             uop_last;
  logic             load_use;

  modport master (
    output rf_valid, rf_ra, rf_rb, rf_use_ra, rf_use_rb, rf_is_lm, rf_is_sm,
           rf_lmsm_mask, ex_mem_rd, ex_rf_we, ex_rf_waddr, ex_redirect,
    input  if_id_stall, if_id_flush, id_rf_stall, id_rf_flush, rf_ex_flush,
           uop_valid, uop_reg, uop_offset, uop_last, load_use
  );

  modport slave (
    input  rf_valid, rf_ra, rf_rb, rf_use_ra, rf_use_rb, rf_is_lm, rf_is_sm,
           rf_lmsm_mask, ex_mem_rd, ex_rf_we, ex_rf_waddr, ex_redirect,
    output if_id_stall, if_id_flush, id_rf_stall, id_rf_flush, rf_ex_flush,
           uop_valid, uop_reg, uop_offset, uop_last, load_use
  );
endinterface

// File: rtl/pipe_hazard_ctrl_prienc.sv
// Lowest-set-bit encoder: picks the next LM/SM register in ascending order.
module lmsm_prienc
  import risc23_pkg::*;
(
  input  logic [NREGS-1:0] mask,
  output logic [REG_W-1:0] index,
  output logic             found,
  output logic [NREGS-1:0] rest
);
  // Scan from the top so the lowest set bit wins; rest clears that bit.
  always_comb begin
    index = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (mask[i]) index = REG_W'(i);
    found = |mask;
    rest  = mask & (mask - NREGS'(1));
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generation for IF/ID, ID/RF, RF/EX plus LM/SM micro-op sequencing.
module pipe_hazard_ctrl
  import risc23_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  hz_state_t        st, st_nxt;
  logic [NREGS-1:0] rem_mask, rem_nxt, cand, rest;
  logic [3:0]       idx, idx_nxt;
  logic             is_sm_q, sm_nxt;
  logic [REG_W-1:0] pe_idx;
  logic             found, in_seq, start, hazard, more;

  assign in_seq = (st == HZ_SEQ);
  assign cand   = in_seq ? rem_mask : hz.rf_lmsm_mask;
  assign start  = !in_seq && hz.rf_valid && (hz.rf_is_lm || hz.rf_is_sm);
  assign more   = (rest != '0);

  lmsm_prienc u_prienc (.mask(cand), .index(pe_idx), .found(found), .rest(rest));

  // A store micro-op reads its register, so it can hit a pending load too.
  assign hazard = hz.ex_mem_rd && hz.ex_rf_we &&
                  ((hz.rf_use_ra && hz.ex_rf_waddr == hz.rf_ra) ||
                   (hz.rf_use_rb && hz.ex_rf_waddr == hz.rf_rb) ||
                   (in_seq && is_sm_q && hz.ex_rf_waddr == pe_idx));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= HZ_IDLE;
      rem_mask <= '0;
      idx      <= '0;
      is_sm_q  <= 1'b0;
    end else begin
      st       <= st_nxt;
      rem_mask <= rem_nxt;
      idx      <= idx_nxt;
      is_sm_q  <= sm_nxt;
    end
  end

  // Next state: redirect aborts, load-use holds, otherwise advance the sequence.
  always_comb begin
    st_nxt  = st;
    rem_nxt = rem_mask;
    idx_nxt = idx;
    sm_nxt  = is_sm_q;
    if (hz.ex_redirect) begin
      st_nxt  = HZ_IDLE;
      rem_nxt = '0;
      idx_nxt = '0;
    end else if (hazard) begin
      // hold
    end else if (start && found && more) begin
      st_nxt  = HZ_SEQ;
      rem_nxt = rest;
      idx_nxt = 4'd1;
      sm_nxt  = hz.rf_is_sm;
    end else if (in_seq) begin
      rem_nxt = rest;
      idx_nxt = more ? idx + 4'd1 : 4'd0;
      st_nxt  = more ? HZ_SEQ : HZ_IDLE;
    end
  end

  // Outputs; micro-op fields read as zero whenever no micro-op is presented.
  always_comb begin
    logic stall, fl_up, fl_ex, uv;
    stall = 1'b0;
    fl_up = 1'b0;
    fl_ex = 1'b0;
    uv    = 1'b0;
    if (hz.ex_redirect) begin
      fl_up = 1'b1;
      fl_ex = 1'b1;
    end else if (hazard) begin
      stall = 1'b1;
      fl_ex = 1'b1;
    end else if (in_seq || start) begin
      uv    = found;
      stall = found && more;
      fl_ex = !found;
    end
    hz.if_id_stall = !rst && stall;
    hz.id_rf_stall = !rst && stall;
    hz.if_id_flush = !rst && fl_up;
    hz.id_rf_flush = !rst && fl_up;
    hz.rf_ex_flush = !rst && fl_ex;
    hz.uop_valid   = !rst && uv;
    hz.uop_last    = !rst && uv && !more;
    hz.uop_reg     = (!rst && uv) ? pe_idx : '0;
    hz.uop_offset  = (!rst && uv && in_seq) ? 16'(idx) * 16'(ADDR_STEP) : 16'd0;
    hz.load_use    = !rst && hazard;
  end
endmodule
